// File: rtl/clkgate_en_ctrl_pkg.sv
// clkgate_pkg: shared types and constants for the clock-gate enable controller.
// Holds the FSM state encoding, default parameter values and the width of the
// shared wake/hold down-counter.
package clkgate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int WAKE_CYCLES_DEF = 2;
  localparam int IDLE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF       = 16;

  // Both latency parameters top out at 255, so eight bits always suffice.
  localparam int DCNT_W = 8;

endpackage

// File: rtl/clkgate_en_ctrl_if.sv
// clkgate_en_ctrl_if: activity requests in, gating-cell enables out.
// The master side is the gated domain / software; the slave side is the
// controller. GATED_CNT exists only when CLKGATE_EN_CTRL_GATE_STATS_EN is defined.
interface clkgate_en_ctrl_if
  import clkgate_pkg::*;
`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
  #(parameter int CNT_W = CNT_W_DEF)
`endif
  ();

  logic REQ;
  logic BUSY;
  logic FORCE_ON;
  logic TEST_MODE;
  logic E;
  logic SE;
  logic RDY;
`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
  logic [CNT_W-1:0] GATED_CNT;
`endif

  modport master (
    output REQ,
    output BUSY,
    output FORCE_ON,
    output TEST_MODE,
`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
    input  GATED_CNT,
`endif
    input  E,
    input  SE,
    input  RDY
  );

  modport slave (
    input  REQ,
    input  BUSY,
    input  FORCE_ON,
    input  TEST_MODE,
`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
    output GATED_CNT,
`endif
    output E,
    output SE,
    output RDY
  );

endinterface

// File: rtl/clkgate_en_ctrl_dcnt.sv
// clkgate_dcnt: loadable 8-bit down-counter with a zero flag.
// One instance is shared by the WAKE and HOLD phases, which never overlap.
// Load wins over decrement; decrement at zero is not expected by the caller.
module clkgate_dcnt
  import clkgate_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DCNT_W-1:0] loadVal,
  input  logic              dec,
  output logic [DCNT_W-1:0] cnt,
  output logic              zero
);

  // Counter register: reset to zero, load a fresh run length, or count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec) begin
      cnt <= cnt - DCNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clkgate_en_ctrl.sv
// clkgate_en_ctrl: drives E and SE of the test-enabled clock-gating cell.
// E rises on activity and RDY follows after WAKE_CYCLES edges; E falls only
// after IDLE_CYCLES consecutive idle samples so short bubbles keep the clock on.
// Optional macro CLKGATE_EN_CTRL_GATE_STATS_EN adds the GATED_CNT statistic.
module clkgate_en_ctrl
  import clkgate_pkg::*;
#(
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
)
(
  input  logic              CK,
  input  logic              RST,
  clkgate_en_ctrl_if.slave  bus
);

  localparam logic [DCNT_W-1:0] WakeLoad = DCNT_W'(WAKE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] IdleLoad = DCNT_W'(IDLE_CYCLES - 1);

  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255 ||
      IDLE_CYCLES < 2 || IDLE_CYCLES > 255 || CNT_W < 1) begin : gParamCheck
    $error("clkgate_en_ctrl: WAKE_CYCLES, IDLE_CYCLES or CNT_W out of range");
  end

  state_t            state;
  logic              eReg;
  logic              rdyReg;
  logic              act;
  logic              cntLoad;
  logic [DCNT_W-1:0] cntLoadVal;
  logic              cntDec;
  logic [DCNT_W-1:0] cnt;
  logic              cntZero;

  assign act = bus.REQ | bus.BUSY | bus.FORCE_ON;

  // Scan must always be able to run the gated clock, so SE bypasses reset and FSM.
  assign bus.SE  = bus.TEST_MODE;
  assign bus.E   = eReg;
  assign bus.RDY = rdyReg;

  clkgate_dcnt uDcnt (
    .clk     (CK),
    .rst     (RST),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .dec     (cntDec),
    .cnt     (cnt),
    .zero    (cntZero)
  );

  // Counter control: load on entry to WAKE/HOLD, count down while the run continues.
  always_comb begin
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    case (state)
      OFF: begin
        if (act) begin
          cntLoad    = 1'b1;
          cntLoadVal = WakeLoad;
        end
      end
      WAKE: begin
        if (!cntZero) cntDec = 1'b1;
      end
      ON: begin
        if (!act) begin
          cntLoad    = 1'b1;
          cntLoadVal = IdleLoad;
        end
      end
      HOLD: begin
        if (!act && cnt != DCNT_W'(1)) cntDec = 1'b1;
      end
      default: ;
    endcase
  end

  // Enable FSM with registered E/RDY; RDY is only ever set while E is already set.
  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= OFF;
      eReg   <= 1'b0;
      rdyReg <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (act) begin
            state <= WAKE;
            eReg  <= 1'b1;
          end
        end
        WAKE: begin
          if (cntZero) begin
            state  <= ON;
            rdyReg <= 1'b1;
          end
        end
        ON: begin
          if (!act) state <= HOLD;
        end
        HOLD: begin
          if (act) begin
            state <= ON;
          end else if (cnt == DCNT_W'(1)) begin
            state  <= OFF;
            eReg   <= 1'b0;
            rdyReg <= 1'b0;
          end
        end
        default: begin
          state  <= OFF;
          eReg   <= 1'b0;
          rdyReg <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
  logic [CNT_W-1:0] gatedCnt;

  assign bus.GATED_CNT = gatedCnt;

  // Saturating count of edges spent with the gated clock switched off.
  always_ff @(posedge CK) begin
    if (RST) begin
      gatedCnt <= '0;
    end else if (!eReg && gatedCnt != '1) begin
      gatedCnt <= gatedCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_clkgate_en_ctrl.sv
// tb_clkgate_en_ctrl: directed vectors for clkgate_en_ctrl with WAKE_CYCLES=2,
// IDLE_CYCLES=8. With CLKGATE_EN_CTRL_GATE_STATS_EN defined the DUT is built
// with CNT_W=4 and the saturating GATED_CNT counter is also exercised.
module tb_clkgate_en_ctrl;

`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
  localparam int TbCntW = 4;
`else
  localparam int TbCntW = 16;
`endif

  logic CK;
  logic RST;
  int   assertCount;
  int   failCount;

`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
  clkgate_en_ctrl_if #(.CNT_W(TbCntW)) bus ();
`else
  clkgate_en_ctrl_if bus ();
`endif

  clkgate_en_ctrl #(
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (8),
    .CNT_W       (TbCntW)
  ) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive inputs, then advance one active edge and settle 1 unit past it.
  task automatic applyStimulus(input logic rst, input logic req, input logic busy,
                               input logic force_on);
    RST          = rst;
    bus.REQ      = req;
    bus.BUSY     = busy;
    bus.FORCE_ON = force_on;
    @(posedge CK);
    #1;
  endtask

  task automatic checkEnRdy(input string tag, input logic expE, input logic expRdy);
    checkOutput({tag, "_E"}, 32'(bus.E), 32'(expE));
    checkOutput({tag, "_RDY"}, 32'(bus.RDY), 32'(expRdy));
  endtask

  initial begin
    int good;
    assertCount   = 0;
    failCount     = 0;
    bus.TEST_MODE = 1'b0;

    // Reset held two edges with REQ high; SE follows TEST_MODE throughout.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkEnRdy("rst0", 1'b0, 1'b0);
    bus.TEST_MODE = 1'b1;
    #1;
    checkOutput("se_rst_hi", 32'(bus.SE), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkEnRdy("rst1", 1'b0, 1'b0);
    bus.TEST_MODE = 1'b0;
    #1;
    checkOutput("se_rst_lo", 32'(bus.SE), 32'd0);

    // Idle after reset: stays off.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("idle", 1'b0, 1'b0);

    // Single-cycle REQ pulse: E at t0, RDY at t0+2, both fall at t0+10.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkEnRdy("pulse_t0", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("pulse_t1", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("pulse_t2", 1'b1, 1'b1);
    for (int k = 3; k <= 9; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkEnRdy($sformatf("pulse_t%0d", k), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("pulse_t10", 1'b0, 1'b0);

    // BUSY with a 5-cycle bubble keeps the clock on; an 8-cycle idle run drops it.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkEnRdy("busy_wake", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkEnRdy("busy_rdy", 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkEnRdy("busy_on", 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkEnRdy($sformatf("bubble%0d", k), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkEnRdy("busy_back", 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkEnRdy($sformatf("idle8_%0d", k), (k < 8), (k < 8));
    end

    // FORCE_ON for 100 edges, then E falls on the 8th edge after release.
    good = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (bus.E === 1'b1 && bus.RDY === (i >= 2)) good++;
    end
    checkOutput("force_cycles_ok", 32'(good), 32'd100);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkEnRdy($sformatf("force_rel%0d", k), (k < 8), (k < 8));
    end

    // Activity returns on the edge HOLD would expire: E never drops.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("rewake", 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkEnRdy("expire_race", 1'b1, 1'b1);

    // Reset in HOLD with cnt=4, then a full-latency re-wake.
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("hold_cnt4", 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkEnRdy("rst_in_hold", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkEnRdy("post_rst_t0", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("post_rst_t1", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEnRdy("post_rst_t2", 1'b1, 1'b1);

`ifdef CLKGATE_EN_CTRL_GATE_STATS_EN
    // GATED_CNT counts off-cycles, saturates at 15, clears on reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("gcnt_rst", 32'(bus.GATED_CNT), 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("gcnt_%0d", i), 32'(bus.GATED_CNT),
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("gcnt_rst2", 32'(bus.GATED_CNT), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
